// File: rtl/ws2812_frame_sched_if.sv
// ---------------------------------------------------------------------------
// ws2812_frame_sched_if
//
// Host-side and encoder-side signal bundle of the WS2812 frame scheduler.
// The host writes pixel words and requests frames; the scheduler reports
// progress and hands one pixel word at a time to the RZ encoder.
//
// Signals:
//   wr_en      host -> sched   pixel buffer write enable
//   wr_addr    host -> sched   pixel index to write (ADDR_W bits)
//   wr_data    host -> sched   24-bit pixel word (GRB order, MSB sent first)
//   start      host -> sched   one-cycle frame start request
//   busy       sched -> host   frame in progress
//   frame_done sched -> host   one-cycle pulse at the end of the latch gap
//   RGB        sched -> enc    pixel word for the encoder
//   done_sig   sched -> enc    one-cycle load strobe, RGB valid in that cycle
//
// Modports:
//   master  host/driver view (drives writes and start)
//   slave   scheduler view
// ---------------------------------------------------------------------------
interface ws2812_frame_sched_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic [23:0]       RGB;
    logic              done_sig;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output start,
        input  busy,
        input  frame_done,
        input  RGB,
        input  done_sig
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  start,
        output busy,
        output frame_done,
        output RGB,
        output done_sig
    );
endinterface

// File: rtl/ws2812_frame_sched.sv
// ---------------------------------------------------------------------------
// ws2812_frame_sched
//
// Upstream stage of the WS2812 RZ encoder. Holds a LED_NUM-deep buffer of
// 24-bit pixel words written by the host. On a start pulse it streams the
// pixels to the encoder one word per 24-bit slot: each word is presented on
// RGB together with a one-cycle done_sig strobe, and successive strobes are
// exactly PIX_CYCLES = 24*BIT_CYCLES clocks apart. After the last pixel's
// slot it holds the line idle for the WS2812 latch gap, then pulses
// frame_done.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   ws2812_frame_sched_if.slave bundle (buffer writes, start, busy,
//         frame_done, RGB, done_sig)
//
// Parameters:
//   LED_NUM       number of LEDs in the chain (1..2**ADDR_W)
//   ADDR_W        width of wr_addr
//   BIT_CYCLES    clocks per encoded bit (must equal the encoder bit period)
//   RESET_CYCLES  clocks of latch gap after the last pixel
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module ws2812_frame_sched #(
    parameter int LED_NUM      = 8,
    parameter int ADDR_W       = 3,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 3000
) (
    input  logic                    clk,
    input  logic                    rst,
    ws2812_frame_sched_if.slave     bus
);

    localparam int PIX_CYCLES = 24 * BIT_CYCLES;
    localparam int CNT_MAX    = (PIX_CYCLES > RESET_CYCLES) ? PIX_CYCLES : RESET_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // WAIT spans PIX_CYCLES-1 cycles (counter 0..PIX_CYCLES-2); together
    // with the single LOAD cycle that gives exactly PIX_CYCLES per pixel.
    localparam logic [CNT_W-1:0]  PIX_TERM = CNT_W'(PIX_CYCLES - 2);
    // LATCH counts 0..RESET_CYCLES; frame_done is registered on the last
    // count so it lands PIX_CYCLES+RESET_CYCLES after the last strobe.
    localparam logic [CNT_W-1:0]  RST_TERM = CNT_W'(RESET_CYCLES);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LED_NUM - 1);
    localparam logic [31:0]       LED_NUM_U = 32'(LED_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  counter;
    logic [23:0]       rgb_q;
    logic              done_q;
    logic              busy_q;
    logic              frame_done_q;

    logic [23:0]       pix_buf [LED_NUM];
    logic              wr_hit;

    // Out-of-range addresses are dropped; zero-extend so the compare is
    // well defined even when LED_NUM fills the whole address space.
    assign wr_hit = bus.wr_en && ({{(32 - ADDR_W){1'b0}}, bus.wr_addr} < LED_NUM_U);

    // Pixel buffer. Writes are accepted in every state; a LOAD on the same
    // edge reads the old word because both sides are plain flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LED_NUM; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (wr_hit) begin
            pix_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Frame sequencer. done_sig and frame_done are single-cycle pulses, so
    // they default low every cycle and are raised only on their edges.
    // A start arriving on the final latch edge is taken directly, which lets
    // back-to-back frames run without an extra idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            counter      <= '0;
            rgb_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                    end
                end

                ST_LOAD: begin
                    rgb_q   <= pix_buf[idx];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    counter <= '0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (counter == PIX_TERM) begin
                        counter <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_LATCH;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_LOAD;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                ST_LATCH: begin
                    if (counter == RST_TERM) begin
                        counter      <= '0;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        if (bus.start) begin
                            state <= ST_LOAD;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.RGB        = rgb_q;
    assign bus.done_sig   = done_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_ws2812_frame_sched
//
// Directed bench for ws2812_frame_sched with LED_NUM=3, ADDR_W=2,
// BIT_CYCLES=4, RESET_CYCLES=20 (PIX_CYCLES=96). Expected strobes and
// frame_done pulses, with their cycle numbers, are queued when a frame is
// started; a monitor pops them whenever the DUT pulses done_sig/frame_done.
// Cycle numbering: cyc equals k right after the k-th rising edge.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_sched;

    localparam int LED_NUM      = 3;
    localparam int ADDR_W       = 2;
    localparam int BIT_CYCLES   = 4;
    localparam int RESET_CYCLES = 20;
    localparam int PIX          = 24 * BIT_CYCLES;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ws2812_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

    ws2812_frame_sched #(
        .LED_NUM      (LED_NUM),
        .ADDR_W       (ADDR_W),
        .BIT_CYCLES   (BIT_CYCLES),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned at;
        bit          is_strobe;
        logic [23:0] rgb;
    } exp_evt_t;

    exp_evt_t    exp_q[$];
    exp_evt_t    mon_evt;
    int unsigned cyc = 0;
    int          num_checks = 0;
    int          num_fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(string name, logic [31:0] actual, logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    // Monitor: every pulse must match the head of the expected queue, and
    // nothing in the queue may go past its cycle unseen.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done_sig || bus.frame_done) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fails++;
                    $display("[TB] FAIL unexpected pulse: got done_sig=%0b frame_done=%0b, expected none (cycle %0d)",
                             bus.done_sig, bus.frame_done, cyc);
                end else begin
                    mon_evt = exp_q.pop_front();
                    check_output("pulse kind done_sig", 32'(bus.done_sig), 32'(mon_evt.is_strobe));
                    check_output("pulse kind frame_done", 32'(bus.frame_done), 32'(!mon_evt.is_strobe));
                    check_output("pulse cycle", cyc, mon_evt.at);
                    if (mon_evt.is_strobe) begin
                        check_output("strobe RGB", 32'(bus.RGB), 32'(mon_evt.rgb));
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                num_checks++;
                num_fails++;
                $display("[TB] FAIL missing pulse: got nothing, expected %s at cycle %0d (now %0d)",
                         exp_q[0].is_strobe ? "done_sig" : "frame_done", exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // Waits until the falling edge following rising edge n.
    task automatic wait_cycle(int unsigned n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic write_pixel(logic [ADDR_W-1:0] addr, logic [23:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic push_frame(int unsigned t, logic [23:0] p0, logic [23:0] p1, logic [23:0] p2);
        exp_q.push_back('{at: t + 1,                          is_strobe: 1'b1, rgb: p0});
        exp_q.push_back('{at: t + 1 + PIX,                    is_strobe: 1'b1, rgb: p1});
        exp_q.push_back('{at: t + 1 + 2 * PIX,                is_strobe: 1'b1, rgb: p2});
        exp_q.push_back('{at: t + 1 + 3 * PIX + RESET_CYCLES, is_strobe: 1'b0, rgb: 24'h0});
    endtask

    // Called at a falling edge: pulses start for the next rising edge (t)
    // and queues the frame that should result from it.
    task automatic apply_stimulus(output int unsigned t, input logic [23:0] p0,
                                  input logic [23:0] p1, input logic [23:0] p2);
        bus.start = 1'b1;
        t = cyc + 1;
        push_frame(t, p0, p1, p2);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Start pulse that should be ignored because a frame is running.
    task automatic stray_start(int unsigned edge_no);
        wait_cycle(edge_no - 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int unsigned t0, t1, t2, t3, t4, t5, t6;

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;

        // 1. Reset values, then a frame from the cleared buffer.
        repeat (5) @(negedge clk);
        check_output("reset RGB", 32'(bus.RGB), 32'h0);
        check_output("reset done_sig", 32'(bus.done_sig), 32'h0);
        check_output("reset busy", 32'(bus.busy), 32'h0);
        check_output("reset frame_done", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        apply_stimulus(t0, 24'h000000, 24'h000000, 24'h000000);
        wait_cycle(t0 + 312);
        check_output("frame1 queue drained", 32'(exp_q.size()), 32'h0);

        // 2/3. Loaded buffer, stray starts while busy, start on frame_done.
        write_pixel(2'd0, 24'hB9E40E);
        write_pixel(2'd1, 24'h0EB9E4);
        write_pixel(2'd2, 24'hFFFFFF);
        apply_stimulus(t1, 24'hB9E40E, 24'h0EB9E4, 24'hFFFFFF);
        check_output("busy at T", 32'(bus.busy), 32'h0);
        wait_cycle(t1 + 1);
        check_output("busy at T+1", 32'(bus.busy), 32'h1);
        stray_start(t1 + 50);
        stray_start(t1 + 250);
        wait_cycle(t1 + 308);
        check_output("busy at T+308", 32'(bus.busy), 32'h1);
        // Start sampled on the frame_done edge (T+309); frame 4 scenario
        // rewrites pixel 2 during this frame, hence 123456 in slot 2.
        bus.start = 1'b1;
        t2 = cyc + 1;
        push_frame(t2, 24'hB9E40E, 24'h0EB9E4, 24'h123456);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("restart edge", cyc, t1 + 309);
        check_output("busy at T+309", 32'(bus.busy), 32'h0);
        check_output("frame_done at T+309", 32'(bus.frame_done), 32'h1);

        // 4. Writes during pixel 0 WAIT, including an out-of-range address.
        wait_cycle(t2 + 20);
        write_pixel(2'd2, 24'h123456);
        write_pixel(2'd3, 24'hAAAAAA);
        wait_cycle(t2 + 312);
        check_output("frame3 queue drained", 32'(exp_q.size()), 32'h0);
        check_output("busy idle after frame3", 32'(bus.busy), 32'h0);

        // 5. Write on the LOAD edge of pixel 1 keeps the old word this frame.
        apply_stimulus(t3, 24'hB9E40E, 24'h0EB9E4, 24'h123456);
        wait_cycle(t3 + PIX);
        write_pixel(2'd1, 24'h654321);
        wait_cycle(t3 + 312);
        check_output("frame4 queue drained", 32'(exp_q.size()), 32'h0);
        apply_stimulus(t4, 24'hB9E40E, 24'h654321, 24'h123456);
        wait_cycle(t4 + 312);
        check_output("frame5 queue drained", 32'(exp_q.size()), 32'h0);

        // 6. Reset in the middle of pixel 1.
        apply_stimulus(t5, 24'hB9E40E, 24'h654321, 24'h123456);
        wait_cycle(t5 + 119);
        check_output("busy before mid reset", 32'(bus.busy), 32'h1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_output("mid reset RGB", 32'(bus.RGB), 32'h0);
        check_output("mid reset busy", 32'(bus.busy), 32'h0);
        check_output("mid reset done_sig", 32'(bus.done_sig), 32'h0);
        check_output("mid reset frame_done", 32'(bus.frame_done), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cycle(t5 + 340);
        check_output("busy after mid reset", 32'(bus.busy), 32'h0);
        apply_stimulus(t6, 24'h000000, 24'h000000, 24'h000000);
        wait_cycle(t6 + 312);
        check_output("frame7 queue drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
